avg_frame_stats: RTL and testbench
==================================

Name: avg_frame_stats

Overview:
- Sits directly downstream of the pairwise averaging stage and consumes its valid/out byte stream.
- Collects one frame of FRAME_LEN averaged samples and computes min, max, sum and rounded mean.
- Computes the mean with a serial restoring divider.
- Presents one summary record per frame to a consumer through a valid/ready handshake.

Parameters:
- FRAME_LEN, 120: number of averaged samples per frame (2..127).
- CNT_W, 7: sample counter width; must satisfy 2^CNT_W > FRAME_LEN.
- SUM_W, 15: accumulator width; must satisfy 2^SUM_W > 255*FRAME_LEN + FRAME_LEN/2.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  sample strobe from averaging stage
- in_data  in  8  averaged sample
- stat_valid  out  1  summary record available
- stat_ready  in  1  consumer accepts record
- stat_min  out  8  minimum sample of frame
- stat_max  out  8  maximum sample of frame
- stat_sum  out  SUM_W  sum of all frame samples
- stat_mean  out  8  round(sum/FRAME_LEN), half rounds up
- drop_flag  out  1  sticky: a sample arrived while not in COLLECT
- busy  out  1  high in DIVIDE or REPORT

Behaviour:
- Reset: the interface for this block is already decided — reset is synchronous and active-high, and clk is the clock.
- On reset:
  - State goes to COLLECT; count=0, sum=0.
  - min register=8'hFF, max register=8'h00.
  - All outputs go to 0: stat_valid, stat_min, stat_max, stat_sum, stat_mean, drop_flag, busy.
  - Reset wins over every other event, including mid-frame, mid-divide, or while stat_valid is high; any partial frame is discarded.
- COLLECT state:
  - Each cycle with in_valid=1: sum+=in_data, min=min(min,in_data), max=max(max,in_data), count++.
  - Cycles with in_valid=0 change nothing; gaps of any length are legal.
  - When the sample is accepted at count==FRAME_LEN-1, the frame is complete.
  - On completion: the updated sum/min/max are latched into working registers, the dividend is loaded with sum+FRAME_LEN/2, count clears, and the state goes to DIVIDE.
- DIVIDE state:
  - Restoring division by the constant FRAME_LEN, one quotient bit per cycle, MSB first, SUM_W cycles.
  - After the last bit, the quotient's low 8 bits go to stat_mean; the quotient never exceeds 255 when the parameter rules hold.
  - stat_min, stat_max and stat_sum are loaded from the working registers.
  - stat_valid is set and the state goes to REPORT.
  - Latency: the frame's last in_valid edge to stat_valid high is SUM_W+1 cycles.
- REPORT state:
  - stat_valid and all stat_* outputs stay stable until a cycle with stat_ready=1.
  - On that edge: stat_valid=0, accumulators reset (sum=0, min=FF, max=00), state goes to COLLECT.
  - stat_ready while stat_valid=0 is ignored.
- Samples outside COLLECT:
  - Any in_valid=1 in DIVIDE or REPORT drops the sample: no accumulator change, drop_flag set to 1.
  - drop_flag clears only on reset.
  - Includes the cycle of the stat_ready handshake; collection restarts on the next cycle.
- busy = (state != COLLECT), registered.
- Boundary values:
  - A frame of all 0s gives min=max=mean=0, sum=0.
  - A frame of all 255s gives sum=255*FRAME_LEN, mean=255, with no overflow.

Optional Feature:
- Macro: AVG_STATS_DELTA_EN.
- When defined:
  - Adds output stat_delta[7:0]: the maximum |in_data[n]-in_data[n-1]| across consecutive accepted samples within the frame.
  - The first sample of a frame contributes no delta.
  - The previous-sample register and the running maximum reset with the accumulators.
  - stat_delta is loaded together with stat_min, is reset to 0, and holds through REPORT.
- When not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Constant frame: 120 samples of 50, back-to-back, stat_ready=1 → stat_valid pulses 16 cycles after the last sample with min=50, max=50, sum=6000, mean=50, drop_flag=0.
- Ramp frame: in_data=0..119 with an idle cycle between every sample → min=0, max=119, sum=7140, mean=60 (59.5 rounds up); with AVG_STATS_DELTA_EN, stat_delta=1.
- Backpressure: all-255 frame, stat_ready held low 10 cycles after stat_valid → outputs stable with sum=30600 and mean=255; then a 1-cycle stat_ready gives stat_valid=0 the next cycle and busy=0.
- Drops: 3 samples of value 200 driven during DIVIDE → drop_flag=1 and the next frame's statistics exclude them; a second frame of value 10 gives min=max=mean=10.
- Reset mid-operation: reset asserted after 60 samples, then again during REPORT → all outputs 0, drop_flag=0; a following 120-sample frame of 7 gives mean=7, sum=840.
- Extremes: alternating 0/255 frame → min=0, max=255, sum=15300, mean=128 (127.5 rounds up); with AVG_STATS_DELTA_EN, stat_delta=255.

Source files
------------

// File: rtl/avg_frame_stats.sv
// avg_frame_stats
//   Frame statistics for the averaged sample stream. The block collects
//   FRAME_LEN samples and computes their min, max and sum. It then derives
//   the rounded mean with a serial restoring divider, one quotient bit per
//   cycle. One summary record per frame is offered on a valid/ready
//   handshake.
//
// Ports
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   in_valid, in_data    : averaged sample strobe and value
//   stat_valid/ready     : summary record handshake
//   stat_min/max/sum/mean: record contents (mean = round-half-up sum/FRAME_LEN)
//   stat_delta           : max |x[n]-x[n-1]| in frame (only with AVG_STATS_DELTA_EN)
//   drop_flag            : sticky, a sample arrived outside COLLECT
//   busy                 : registered, high in DIVIDE or REPORT
//
// Optional feature macro: AVG_STATS_DELTA_EN
module avg_frame_stats #(
  parameter int FRAME_LEN = 120,
  parameter int CNT_W     = 7,
  parameter int SUM_W     = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             stat_valid,
  input  logic             stat_ready,
  output logic [7:0]       stat_min,
  output logic [7:0]       stat_max,
  output logic [SUM_W-1:0] stat_sum,
  output logic [7:0]       stat_mean,
`ifdef AVG_STATS_DELTA_EN
  output logic [7:0]       stat_delta,
`endif
  output logic             drop_flag,
  output logic             busy
);

  localparam int DC_W = $clog2(SUM_W + 1);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(FRAME_LEN - 1);
  localparam logic [SUM_W-1:0] HALF_C  = SUM_W'(FRAME_LEN / 2);
  localparam logic [CNT_W:0]   DIV_C   = (CNT_W + 1)'(FRAME_LEN);
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(SUM_W);

  typedef enum logic [1:0] {COLLECT = 2'd0, DIVIDE = 2'd1, REPORT = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d, wsum_q, wsum_d, dvd_q, dvd_d;
  logic [7:0]       min_q, min_d, max_q, max_d, wmin_q, wmin_d, wmax_q, wmax_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic             stat_valid_q, stat_valid_d, drop_q, drop_d, busy_q, busy_d;
  logic [7:0]       stat_min_q, stat_min_d, stat_max_q, stat_max_d, stat_mean_q, stat_mean_d;
  logic [SUM_W-1:0] stat_sum_q, stat_sum_d;

  logic [SUM_W-1:0] acc_sum_s;
  logic [7:0]       acc_min_s, acc_max_s;
  logic [CNT_W:0]   rem_sh_s;
  logic             q_bit_s;

`ifdef AVG_STATS_DELTA_EN
  logic [7:0] prev_q, prev_d, dmax_q, dmax_d, wdelta_q, wdelta_d, stat_delta_q, stat_delta_d;
  logic [7:0] diff_s, acc_delta_s;
`endif

  // Running statistics including the sample currently on in_data.
  always_comb begin
    acc_sum_s = sum_q + SUM_W'(in_data);
    acc_min_s = (in_data < min_q) ? in_data : min_q;
    acc_max_s = (in_data > max_q) ? in_data : max_q;
`ifdef AVG_STATS_DELTA_EN
    diff_s = (in_data >= prev_q) ? (in_data - prev_q) : (prev_q - in_data);
    // The first sample of a frame has no predecessor, so it contributes no delta.
    acc_delta_s = ((cnt_q != {CNT_W{1'b0}}) && (diff_s > dmax_q)) ? diff_s : dmax_q;
`endif
    // Restoring step: shift the next dividend bit into the partial remainder.
    // The quotient bits shift into the low end of the dividend register.
    rem_sh_s = {rem_q, dvd_q[SUM_W-1]};
    q_bit_s  = (rem_sh_s >= DIV_C);
  end

  // Next-state and datapath update for COLLECT / DIVIDE / REPORT.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    min_d        = min_q;
    max_d        = max_q;
    wsum_d       = wsum_q;
    wmin_d       = wmin_q;
    wmax_d       = wmax_q;
    dvd_d        = dvd_q;
    rem_d        = rem_q;
    dcnt_d       = dcnt_q;
    stat_valid_d = stat_valid_q;
    stat_min_d   = stat_min_q;
    stat_max_d   = stat_max_q;
    stat_sum_d   = stat_sum_q;
    stat_mean_d  = stat_mean_q;
`ifdef AVG_STATS_DELTA_EN
    prev_d       = prev_q;
    dmax_d       = dmax_q;
    wdelta_d     = wdelta_q;
    stat_delta_d = stat_delta_q;
`endif
    // Any sample offered outside COLLECT is discarded but remembered.
    drop_d = drop_q | (in_valid & (state_q != COLLECT));

    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          sum_d = acc_sum_s;
          min_d = acc_min_s;
          max_d = acc_max_s;
`ifdef AVG_STATS_DELTA_EN
          prev_d = in_data;
          dmax_d = acc_delta_s;
`endif
          if (cnt_q == LAST_C) begin
            wsum_d  = acc_sum_s;
            wmin_d  = acc_min_s;
            wmax_d  = acc_max_s;
`ifdef AVG_STATS_DELTA_EN
            wdelta_d = acc_delta_s;
`endif
            // Adding FRAME_LEN/2 makes the truncating divide round half up.
            dvd_d   = acc_sum_s + HALF_C;
            rem_d   = {CNT_W{1'b0}};
            dcnt_d  = {DC_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            state_d = DIVIDE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = COLLECT;
        end
      end
      DIVIDE: begin
        // SUM_W shift/subtract steps, then one cycle to publish the record.
        if (dcnt_q == DC_LAST) begin
          stat_mean_d  = dvd_q[7:0];
          stat_min_d   = wmin_q;
          stat_max_d   = wmax_q;
          stat_sum_d   = wsum_q;
`ifdef AVG_STATS_DELTA_EN
          stat_delta_d = wdelta_q;
`endif
          stat_valid_d = 1'b1;
          state_d      = REPORT;
        end else begin
          rem_d  = q_bit_s ? CNT_W'(rem_sh_s - DIV_C) : CNT_W'(rem_sh_s);
          dvd_d  = {dvd_q[SUM_W-2:0], q_bit_s};
          dcnt_d = dcnt_q + DC_W'(1);
        end
      end
      REPORT: begin
        if (stat_ready) begin
          stat_valid_d = 1'b0;
          sum_d        = {SUM_W{1'b0}};
          min_d        = 8'hFF;
          max_d        = 8'h00;
`ifdef AVG_STATS_DELTA_EN
          prev_d       = 8'h00;
          dmax_d       = 8'h00;
`endif
          state_d      = COLLECT;
        end else begin
          state_d = REPORT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase

    busy_d = (state_d != COLLECT);
  end

  // State and datapath registers; synchronous reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      cnt_q        <= {CNT_W{1'b0}};
      sum_q        <= {SUM_W{1'b0}};
      min_q        <= 8'hFF;
      max_q        <= 8'h00;
      wsum_q       <= {SUM_W{1'b0}};
      wmin_q       <= 8'h00;
      wmax_q       <= 8'h00;
      dvd_q        <= {SUM_W{1'b0}};
      rem_q        <= {CNT_W{1'b0}};
      dcnt_q       <= {DC_W{1'b0}};
      stat_valid_q <= 1'b0;
      stat_min_q   <= 8'h00;
      stat_max_q   <= 8'h00;
      stat_sum_q   <= {SUM_W{1'b0}};
      stat_mean_q  <= 8'h00;
      drop_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef AVG_STATS_DELTA_EN
      prev_q       <= 8'h00;
      dmax_q       <= 8'h00;
      wdelta_q     <= 8'h00;
      stat_delta_q <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sum_q        <= sum_d;
      min_q        <= min_d;
      max_q        <= max_d;
      wsum_q       <= wsum_d;
      wmin_q       <= wmin_d;
      wmax_q       <= wmax_d;
      dvd_q        <= dvd_d;
      rem_q        <= rem_d;
      dcnt_q       <= dcnt_d;
      stat_valid_q <= stat_valid_d;
      stat_min_q   <= stat_min_d;
      stat_max_q   <= stat_max_d;
      stat_sum_q   <= stat_sum_d;
      stat_mean_q  <= stat_mean_d;
      drop_q       <= drop_d;
      busy_q       <= busy_d;
`ifdef AVG_STATS_DELTA_EN
      prev_q       <= prev_d;
      dmax_q       <= dmax_d;
      wdelta_q     <= wdelta_d;
      stat_delta_q <= stat_delta_d;
`endif
    end
  end

  assign stat_valid = stat_valid_q;
  assign stat_min   = stat_min_q;
  assign stat_max   = stat_max_q;
  assign stat_sum   = stat_sum_q;
  assign stat_mean  = stat_mean_q;
  assign drop_flag  = drop_q;
  assign busy       = busy_q;
`ifdef AVG_STATS_DELTA_EN
  assign stat_delta = stat_delta_q;
`endif

endmodule

// File: tb/tb_avg_frame_stats.sv
// Self-checking bench for avg_frame_stats: expected frame records are pushed
// to a scoreboard queue as frames are driven and popped when the DUT reports.
module tb_avg_frame_stats;

  localparam int FRAME_LEN = 120;
  localparam int CNT_W     = 7;
  localparam int SUM_W     = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             stat_ready = 1'b0;
  logic             stat_valid;
  logic [7:0]       stat_min, stat_max, stat_mean;
  logic [SUM_W-1:0] stat_sum;
  logic             drop_flag, busy;
`ifdef AVG_STATS_DELTA_EN
  logic [7:0]       stat_delta;
`endif

  typedef struct {
    int mn;
    int mx;
    int sm;
    int mean;
    int dl;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  avg_frame_stats #(.FRAME_LEN(FRAME_LEN), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .stat_valid(stat_valid), .stat_ready(stat_ready),
    .stat_min(stat_min), .stat_max(stat_max), .stat_sum(stat_sum),
    .stat_mean(stat_mean),
`ifdef AVG_STATS_DELTA_EN
    .stat_delta(stat_delta),
`endif
    .drop_flag(drop_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sample_val(input int kind, input int val, input int i);
    case (kind)
      0:       return val;
      1:       return i;
      default: return (i % 2 == 1) ? 255 : 0;
    endcase
  endfunction

  // Drive n samples (gap idle cycles after each); push a full-frame record when asked.
  task automatic run_frame(input int kind, input int val, input int n, input int gap, input bit push);
    rec_t r;
    int prev, v, d;
    r.mn = 255; r.mx = 0; r.sm = 0; r.dl = 0; prev = 0;
    for (int i = 0; i < n; i++) begin
      v = sample_val(kind, val, i);
      in_valid = 1'b1;
      in_data  = 8'(v);
      tick();
      in_valid = 1'b0;
      if (v < r.mn) r.mn = v;
      if (v > r.mx) r.mx = v;
      r.sm += v;
      d = (v > prev) ? v - prev : prev - v;
      if (i > 0 && d > r.dl) r.dl = d;
      prev = v;
      for (int g = 0; g < gap; g++) tick();
    end
    r.mean = (r.sm + FRAME_LEN / 2) / FRAME_LEN;
    if (push) exp_q.push_back(r);
  endtask

  // Wait (bounded) for stat_valid; cyc counts cycles since the frame's last sample edge.
  task automatic await_stat(input string tag, input int start, input int gap);
    int cyc;
    cyc = start + gap;
    while (!stat_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    check_eq({tag, "_latency"}, cyc, SUM_W + 1);
  endtask

  task automatic pop_check(input string tag);
    rec_t r;
    check_eq({tag, "_sb_nonempty"}, int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      check_eq({tag, "_valid"}, int'(stat_valid), 1);
      check_eq({tag, "_min"},  int'(stat_min),  r.mn);
      check_eq({tag, "_max"},  int'(stat_max),  r.mx);
      check_eq({tag, "_sum"},  int'(stat_sum),  r.sm);
      check_eq({tag, "_mean"}, int'(stat_mean), r.mean);
`ifdef AVG_STATS_DELTA_EN
      check_eq({tag, "_delta"}, int'(stat_delta), r.dl);
`endif
    end
  endtask

  task automatic ack(input string tag);
    stat_ready = 1'b1;
    tick();
    stat_ready = 1'b0;
    check_eq({tag, "_ack_valid"}, int'(stat_valid), 0);
    check_eq({tag, "_ack_busy"},  int'(busy), 0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_valid"}, int'(stat_valid), 0);
    check_eq({tag, "_min"},   int'(stat_min), 0);
    check_eq({tag, "_max"},   int'(stat_max), 0);
    check_eq({tag, "_sum"},   int'(stat_sum), 0);
    check_eq({tag, "_mean"},  int'(stat_mean), 0);
    check_eq({tag, "_drop"},  int'(drop_flag), 0);
    check_eq({tag, "_busy"},  int'(busy), 0);
`ifdef AVG_STATS_DELTA_EN
    check_eq({tag, "_delta"}, int'(stat_delta), 0);
`endif
  endtask

  initial begin
    rec_t scrap;
    repeat (3) tick();
    reset = 1'b0;
    check_zero("rst");

    // Constant frame, back-to-back, ready held high.
    stat_ready = 1'b1;
    run_frame(0, 50, FRAME_LEN, 0, 1'b1);
    await_stat("const", 0, 0);
    check_eq("const_busy", int'(busy), 1);
    pop_check("const");
    check_eq("const_drop", int'(drop_flag), 0);
    ack("const");

    // Ramp with an idle cycle after every sample.
    run_frame(1, 0, FRAME_LEN, 1, 1'b1);
    await_stat("ramp", 0, 1);
    pop_check("ramp");
    ack("ramp");

    // All-255 frame with backpressure.
    run_frame(0, 255, FRAME_LEN, 0, 1'b1);
    await_stat("bp", 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_hold_valid", int'(stat_valid), 1);
      check_eq("bp_hold_sum", int'(stat_sum), 30600);
      check_eq("bp_hold_mean", int'(stat_mean), 255);
    end
    pop_check("bp");
    ack("bp");

    // Three samples of 200 during DIVIDE are dropped.
    run_frame(0, 10, FRAME_LEN, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'd200;
      tick();
    end
    in_valid = 1'b0;
    await_stat("dropA", 3, 0);
    check_eq("dropA_flag", int'(drop_flag), 1);
    pop_check("dropA");
    ack("dropA");
    run_frame(0, 10, FRAME_LEN, 0, 1'b1);
    await_stat("dropB", 0, 0);
    pop_check("dropB");
    check_eq("dropB_flag", int'(drop_flag), 1);
    ack("dropB");

    // Reset mid-frame, then a full frame, then reset during REPORT.
    run_frame(0, 99, 60, 0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("rst_mid");
    run_frame(0, 7, FRAME_LEN, 0, 1'b1);
    await_stat("seven1", 0, 0);
    pop_check("seven1");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("rst_rep");
    tick();
    check_eq("rst_rep_stay", int'(stat_valid), 0);
    run_frame(0, 7, FRAME_LEN, 0, 1'b1);
    await_stat("seven2", 0, 0);
    pop_check("seven2");
    ack("seven2");

    // Alternating 0/255 extremes.
    run_frame(2, 0, FRAME_LEN, 0, 1'b1);
    await_stat("alt", 0, 0);
    pop_check("alt");
    ack("alt");

    check_eq("sb_drained", exp_q.size(), 0);
    while (exp_q.size() > 0) scrap = exp_q.pop_front();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
